// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control, pattern and playback signals of the song sequencer
interface song_sequencer_if;
  logic        start;
  logic        pause;
  logic        stop;
  logic [19:0] sect_notes;
  logic [4:0]  step;
  logic [1:0]  sect_sel;
  logic [2:0]  arr_idx;
  logic        beat_tick;
  logic [4:0]  exp_notes;
  logic        playing;
  logic        song_done;

  modport master (
    output start, pause, stop, sect_notes,
    input  step, sect_sel, arr_idx, beat_tick, exp_notes, playing, song_done
  );

  modport slave (
    input  start, pause, stop, sect_notes,
    output step, sect_sel, arr_idx, beat_tick, exp_notes, playing, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - eighth-note beat generator walking a section arrangement
// Optional eight-tick count-in before playback: SONG_SEQUENCER_COUNT_IN_EN
module song_sequencer #(
  parameter int          BEAT_DIV    = 12500000,
  parameter int          SECT_LEN    = 32,
  parameter int          ARR_LEN     = 8,
  parameter logic [15:0] ARRANGEMENT = 16'b00_10_11_10_01_10_01_00
) (
  input logic             clk,
  input logic             resetn,
  song_sequencer_if.slave bus
);
  localparam int              DIV_W    = $clog2(BEAT_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BEAT_DIV - 1);
  localparam logic [4:0]      STEP_MAX = 5'(SECT_LEN - 1);
  localparam logic [2:0]      ARR_MAX  = 3'(ARR_LEN - 1);

`ifdef SONG_SEQUENCER_COUNT_IN_EN
  typedef enum logic [2:0] {S_IDLE, S_COUNT_IN, S_PLAY, S_PAUSED, S_DONE} state_t;
  localparam state_t START_STATE = S_COUNT_IN;
`else
  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_PAUSED, S_DONE} state_t;
  localparam state_t START_STATE = S_PLAY;
`endif

  state_t           state, state_next, resume_state;
  logic [DIV_W-1:0] div;
  logic [4:0]       step;
  logic [2:0]       arr_idx;
  logic [1:0]       sect_sel;
  logic [4:0]       exp_notes;
  logic             playing, song_done;
  logic             counting, next_counting, active, tick, last_beat, restart;

`ifdef SONG_SEQUENCER_COUNT_IN_EN
  logic resume_count;
  assign counting      = (state == S_COUNT_IN);
  assign next_counting = (state_next == S_COUNT_IN);
  assign resume_state  = resume_count ? S_COUNT_IN : S_PLAY;

  // Remember whether the pause interrupted an unfinished count-in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      resume_count <= 1'b0;
    else if (state_next == S_PAUSED && state != S_PAUSED)
      resume_count <= counting && !(tick && step == 5'd7);
  end
`else
  assign counting      = 1'b0;
  assign next_counting = 1'b0;
  assign resume_state  = S_PLAY;
`endif

  assign active    = (state == S_PLAY) || counting;
  assign tick      = active && (div == DIV_MAX);
  assign last_beat = tick && (state == S_PLAY) && (step == STEP_MAX) && (arr_idx == ARR_MAX);
  assign restart   = (state == S_IDLE || state == S_DONE) && (state_next == START_STATE);
  assign sect_sel  = ARRANGEMENT[2*arr_idx +: 2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start && !bus.pause) state_next = START_STATE;
      S_PLAY: begin
        if (last_beat)      state_next = S_DONE;
        else if (bus.pause) state_next = S_PAUSED;
      end
`ifdef SONG_SEQUENCER_COUNT_IN_EN
      S_COUNT_IN: begin
        if (bus.pause)                   state_next = S_PAUSED;
        else if (tick && step == 5'd7)   state_next = S_PLAY;
      end
`endif
      S_PAUSED: if (bus.start && !bus.pause) state_next = resume_state;
      default: state_next = S_IDLE;
    endcase
    if (bus.stop) state_next = S_IDLE;
  end

  // Counters keep running through the cycle a pause arrives in; PAUSED freezes them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div     <= '0;
      step    <= '0;
      arr_idx <= '0;
    end else if (state_next == S_IDLE || restart) begin
      div     <= '0;
      step    <= '0;
      arr_idx <= '0;
    end else if (active) begin
      if (!tick) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (counting)
          step <= (step == 5'd7) ? 5'd0 : step + 1'b1;
        else if (step != STEP_MAX)
          step <= step + 1'b1;
        else if (arr_idx != ARR_MAX) begin
          step    <= '0;
          arr_idx <= arr_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_notes <= '0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      exp_notes <= (state_next == S_PLAY) ? bus.sect_notes[5*sect_sel +: 5] : 5'd0;
      playing   <= (state_next == S_PLAY) || next_counting;
      song_done <= (state == S_PLAY) && (state_next == S_DONE);
    end
  end

  assign bus.step      = step;
  assign bus.sect_sel  = sect_sel;
  assign bus.arr_idx   = arr_idx;
  assign bus.beat_tick = tick;
  assign bus.exp_notes = exp_notes;
  assign bus.playing   = playing;
  assign bus.song_done = song_done;
endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed vector table plus randomized run against a song-position model
module tb_song_sequencer;
  localparam int          BEAT_DIV    = 4;
  localparam int          SECT_LEN    = 4;
  localparam int          ARR_LEN     = 3;
  localparam logic [15:0] ARRANGEMENT = 16'b11_01_10_11_11_10_01_00;
  localparam int          TOTAL       = SECT_LEN * ARR_LEN;
  localparam int          M_IDLE = 0, M_PLAY = 1, M_PAUSED = 2, M_DONE = 3;
  localparam logic [4:0]  N0 = 5'b00101, N1 = 5'b01010, N2 = 5'b10001;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  song_sequencer_if bus();

  song_sequencer #(
    .BEAT_DIV(BEAT_DIV), .SECT_LEN(SECT_LEN), .ARR_LEN(ARR_LEN), .ARRANGEMENT(ARRANGEMENT)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int s; int p; int t; int e_ticks;
    int e_step; int e_arr; int e_sel; int e_tick; int e_play; int e_done;
    logic [4:0] e_exp;
  } vec_t;

  int total = 0;
  int bad = 0;

  // Model: song position in beats, phase in clocks since the last beat
  int         m_mode, m_pos, m_phase;
  logic [4:0] m_exp;
  logic       m_done;
  logic [15:0] arr_map = ARRANGEMENT;

  function automatic logic [1:0] sel_of(input int pos);
    int a = pos / SECT_LEN;
    return arr_map[2*a +: 2];
  endfunction

  function automatic logic [31:0] model_out();
    return {14'd0, 5'(m_pos % SECT_LEN), 3'(m_pos / SECT_LEN), sel_of(m_pos),
            (m_mode == M_PLAY && m_phase == BEAT_DIV - 1), (m_mode == M_PLAY), m_done, m_exp};
  endfunction

  function automatic logic [31:0] dut_out();
    return {14'd0, bus.step, bus.arr_idx, bus.sect_sel, bus.beat_tick, bus.playing,
            bus.song_done, bus.exp_notes};
  endfunction

  function automatic logic [31:0] vec_out(input vec_t v);
    return {14'd0, 5'(v.e_step), 3'(v.e_arr), 2'(v.e_sel), 1'(v.e_tick), 1'(v.e_play),
            1'(v.e_done), v.e_exp};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_phase = 0; m_exp = 5'd0; m_done = 1'b0;
  endtask

  task automatic model_update(input bit s, input bit p, input bit t, input logic [19:0] n);
    int nmode = m_mode;
    bit tk = (m_mode == M_PLAY) && (m_phase == BEAT_DIV - 1);
    logic [19:0] sh;
    if (t) nmode = M_IDLE;
    else if (m_mode == M_PLAY) begin
      if (tk && m_pos == TOTAL - 1) nmode = M_DONE;
      else if (p) nmode = M_PAUSED;
    end else if (s && !p) nmode = M_PLAY;
    m_done = (m_mode == M_PLAY) && (nmode == M_DONE);
    sh = n >> (5 * sel_of(m_pos));
    m_exp = (nmode == M_PLAY) ? sh[4:0] : 5'd0;
    if (nmode == M_IDLE || (nmode == M_PLAY && (m_mode == M_IDLE || m_mode == M_DONE))) begin
      m_pos = 0; m_phase = 0;
    end else if (m_mode == M_PLAY) begin
      if (tk) begin
        m_phase = 0;
        if (m_pos < TOTAL - 1) m_pos++;
      end else m_phase++;
    end
    m_mode = nmode;
  endtask

  task automatic cyc(input bit s, input bit p, input bit t, input logic [19:0] n);
    bus.start = s; bus.pause = p; bus.stop = t; bus.sect_notes = n;
    @(posedge clk);
    if (resetn) model_update(s, p, t, n);
    #1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    vec_t vt[24];
    logic [19:0] notes;
    int seen;
    notes = {5'd0, N2, N1, N0};
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; bus.sect_notes = notes;
    //         n  s p t tk st ar se bt pl dn exp
    vt[0]  = '{1, 1,0,0, 0, 0,0,0, 0,1,0, N0};
    vt[1]  = '{3, 0,0,0, 1, 0,0,0, 1,1,0, N0};
    vt[2]  = '{1, 0,0,0, 0, 1,0,0, 0,1,0, N0};
    vt[3]  = '{7, 0,0,0, 2, 2,0,0, 1,1,0, N0};
    vt[4]  = '{4, 0,0,0, 1, 3,0,0, 1,1,0, N0};
    vt[5]  = '{1, 0,0,0, 0, 0,1,1, 0,1,0, N0};
    vt[6]  = '{1, 0,0,0, 0, 0,1,1, 0,1,0, N1};
    vt[7]  = '{15,0,0,0, 4, 0,2,2, 0,1,0, N1};
    vt[8]  = '{1, 0,0,0, 0, 0,2,2, 0,1,0, N2};
    vt[9]  = '{14,0,0,0, 4, 3,2,2, 1,1,0, N2};
    vt[10] = '{1, 0,0,0, 0, 3,2,2, 0,0,1, 5'd0};
    vt[11] = '{8, 0,0,0, 0, 3,2,2, 0,0,0, 5'd0};
    vt[12] = '{1, 1,0,0, 0, 0,0,0, 0,1,0, N2};
    vt[13] = '{2, 0,0,0, 0, 0,0,0, 0,1,0, N0};
    vt[14] = '{1, 0,1,0, 0, 0,0,0, 0,0,0, 5'd0};
    vt[15] = '{100,0,0,0,0, 0,0,0, 0,0,0, 5'd0};
    vt[16] = '{1, 1,0,0, 1, 0,0,0, 1,1,0, N0};
    vt[17] = '{1, 0,0,0, 0, 1,0,0, 0,1,0, N0};
    vt[18] = '{1, 1,0,1, 0, 0,0,0, 0,0,0, 5'd0};
    vt[19] = '{1, 1,0,0, 0, 0,0,0, 0,1,0, N0};
    vt[20] = '{1, 0,1,0, 0, 0,0,0, 0,0,0, 5'd0};
    vt[21] = '{1, 1,1,0, 0, 0,0,0, 0,0,0, 5'd0};
    vt[22] = '{5, 0,0,0, 0, 0,0,0, 0,0,0, 5'd0};
    vt[23] = '{1, 0,0,1, 0, 0,0,0, 0,0,0, 5'd0};

    model_reset();
    #12;
    check("reset_state", dut_out(), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      seen = 0;
      for (int c = 0; c < vt[i].n; c++) begin
        if (c == 0) cyc(vt[i].s != 0, vt[i].p != 0, vt[i].t != 0, notes);
        else cyc(1'b0, 1'b0, 1'b0, notes);
        if (bus.beat_tick) seen++;
      end
      check($sformatf("vec%0d_outputs", i), dut_out(), vec_out(vt[i]));
      check($sformatf("vec%0d_tick_count", i), 32'(seen), 32'(vt[i].e_ticks));
    end

    cyc(1'b1, 1'b0, 1'b0, notes);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, notes);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("async_reset_mid_play", dut_out(), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, notes);
    check("start_after_reset", dut_out(), {14'd0, 5'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, N0});

    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0,
          20'($urandom));
      check($sformatf("random_cycle%0d", k), dut_out(), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
